router_input_arbiter: RTL
=========================

// Module: router_input_arbiter
// PURPOSE
//  Round-robin packet arbiter sharing the router's single 8-bit input port (dut_inp/inp_valid)
//  among NUM_REQ byte-stream sources. Grants whole packets only and honours router busy.
//  Aborts cleanly on router error, source underrun or over-length packets.
//  Sits between the TB/SoC packet sources and the router DUT input.
// PARAMETERS
//  NUM_REQ      4    number of requesters (2..8)
//  DATA_W       8    byte width; must equal router dut_inp width
//  MAX_PKT_LEN  64   max bytes per packet before forced truncation (2..255)
// PORTS
//  clk          in   1                  clock, all logic on posedge
//  reset        in   1                  asynchronous, active-low reset
//  req_data     in   NUM_REQ*DATA_W     requester bytes, req i at [i*DATA_W +: DATA_W]
//  req_valid    in   NUM_REQ            requester byte valid
//  req_last     in   NUM_REQ            marks final byte of packet (qualified by req_valid)
//  req_ready    out  NUM_REQ            byte accepted when req_valid&req_ready
//  dut_inp      out  DATA_W             byte to router
//  inp_valid    out  1                  router input valid, contiguous for whole packet
//  busy         in   1                  router cannot start a new packet
//  error        in   1                  router error indication
//  grant_id     out  $clog2(NUM_REQ)    current/last granted requester
//  grant_vld    out  1                  high in XFER and DRAIN
//  abort_pulse  out  1                  1-cycle pulse when a packet is aborted
//  abort_cause  out  2                  0=router error,1=underrun,2=over-length; held until next abort
//  rd           in   1                  stats read strobe
//  addr         in   8                  stats address
//  rdata        out  32                 stats read data
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE; req_ready=0; dut_inp=0; inp_valid=0; grant_id=NUM_REQ-1;
//   grant_vld=0; abort_pulse=0; abort_cause=0; rdata=0; counters=0. Mid-packet reset drops packet.
//  FSM IDLE->XFER->GAP->IDLE; XFER->DRAIN->GAP on abort.
//  IDLE: if busy=0 and any req_valid: winner = first valid searching grant_id+1, +2 ... (wrap mod NUM_REQ);
//   register grant_id, go XFER. busy=1 or no request: stay. busy ignored outside IDLE.
//  XFER: req_ready[grant_id]=1 (combinational from state), others 0. Each cycle registers
//   dut_inp<=req_data[g], inp_valid<=req_valid[g]: one-cycle latency accept->router.
//   Byte counter increments per accepted byte.
//   valid&last -> GAP (last byte forwarded).
//   req_valid[g]=0 -> underrun abort.
//   error=1 sampled -> error abort (error has priority over last on same cycle).
//   Counter reaches MAX_PKT_LEN with no last -> over-length abort (MAX_PKT_LEN bytes forwarded).
//  Abort: inp_valid<=0 next cycle, abort_pulse=1 for one cycle, abort_cause set, go DRAIN.
//   If the aborting byte carries last, go GAP instead of DRAIN.
//  DRAIN: req_ready[g]=1, bytes discarded, inp_valid=0; leave on valid&last -> GAP.
//  GAP: one cycle, inp_valid=0, req_ready=0 (packet separator); then IDLE.
//  Minimum 1 idle cycle between packets; back-to-back packets from the same source re-arbitrate.
//  dut_inp holds last value when inp_valid=0.
// CONFIGURATION
//  ROUTER_ARB_STATS_EN defined: per-requester 32-bit packet-complete counters (wrap at 2^32);
//   one 32-bit abort counter. rd=1 registers rdata next cycle:
//   addr i (<NUM_REQ) = pkt count i; addr NUM_REQ = abort count; other addr = 32'hDEAD_BEEF.
//   Counters increment when a packet enters GAP from XFER without abort; abort count increments on abort_pulse.
//  Undefined: no counters; rd/addr ignored; rdata constant 0.
// TESTING
//  1. req0 sends 4-byte pkt {11,22,33,44}, busy=0 -> inp_valid high 4 cycles starting 2 cycles after
//     req_valid; same bytes in order; then 1 GAP cycle.
//  2. All 4 requesters valid continuously, 3-byte pkts -> grant order 0,1,2,3,0; no byte interleave.
//  3. busy=1 for 10 cycles with req1 pending -> no grant, inp_valid=0; grant within 1 cycle of busy=0.
//  4. error pulsed on 2nd byte of 6-byte pkt -> inp_valid drops after that byte.
//     abort_pulse=1, abort_cause=0; remaining 4 bytes drained; next pkt proceeds normally.
//  5. req2 deasserts valid mid-pkt -> abort_cause=1. Separately, MAX_PKT_LEN=64 with 70-byte pkt
//     -> 64 bytes forwarded, abort_cause=2.
//  6. STATS_EN: after test 2, rd addr 0 -> 2, addr 4 -> 0; reset low mid-packet -> all outputs/counters 0.

Source files
------------

// File: rtl/router_input_arbiter.sv
// -----------------------------------------------------------------------------
// router_input_arbiter
//   Round-robin packet arbiter that shares the router's single byte-wide input
//   port among NUM_REQ byte-stream sources. Whole packets are granted, router
//   busy is honoured only when choosing the next packet, and a packet is
//   aborted cleanly on router error, source underrun or over-length.
//
//   Optional feature macro: ROUTER_ARB_STATS_EN
//     defined   -> per-requester packet counters, abort counter, read port
//     undefined -> rd/addr ignored, rdata tied to zero
//
// Ports
//   clk          clock, all logic on posedge
//   reset        asynchronous active-low reset
//   req_data     requester bytes, requester i at [i*DATA_W +: DATA_W]
//   req_valid    requester byte valid
//   req_last     final byte of packet (qualified by req_valid)
//   req_ready    byte accepted when req_valid & req_ready
//   dut_inp      byte to router (holds value while inp_valid is low)
//   inp_valid    router input valid, contiguous for a whole packet
//   busy         router cannot start a new packet
//   error        router error indication
//   grant_id     current/last granted requester
//   grant_vld    high while a packet is being transferred or drained
//   abort_pulse  one-cycle pulse when a packet is aborted
//   abort_cause  0=router error, 1=underrun, 2=over-length; held until next abort
//   rd/addr      statistics read strobe and address
//   rdata        statistics read data (registered)
// -----------------------------------------------------------------------------
module router_input_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 8,
  parameter int MAX_PKT_LEN = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0]          req_last,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [DATA_W-1:0]           dut_inp,
  output logic                        inp_valid,
  input  logic                        busy,
  input  logic                        error,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        grant_vld,
  output logic                        abort_pulse,
  output logic [1:0]                  abort_cause,
  input  logic                        rd,
  input  logic [7:0]                  addr,
  output logic [31:0]                 rdata
);

  localparam int GW = $clog2(NUM_REQ);
  localparam logic [7:0] LEN_LAST    = 8'(MAX_PKT_LEN - 1);
  localparam logic [1:0] CAUSE_ERR   = 2'd0;
  localparam logic [1:0] CAUSE_UNDER = 2'd1;
  localparam logic [1:0] CAUSE_LEN   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  state_t            state_r;
  logic [GW-1:0]     grant_id_r;
  logic [7:0]        cnt_r;
  logic [DATA_W-1:0] dut_inp_r;
  logic              inp_valid_r;
  logic              abort_pulse_r;
  logic [1:0]        abort_cause_r;

  logic [GW:0]       pick_s;
  logic [DATA_W-1:0] sel_data_s;
  logic              sel_valid_s;
  logic              sel_last_s;
  logic              abort_s;
  logic [1:0]        cause_s;

  // Round-robin search starting one past the last grant. Scanning from the
  // farthest candidate to the nearest lets the nearest valid one win.
  // Result is {found, id}.
  function automatic logic [GW:0] rr_pick(input logic [GW-1:0]      last_id,
                                          input logic [NUM_REQ-1:0] vld);
    logic [GW:0] res;
    int          idx;
    res = {1'b0, last_id};
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(last_id) + k) % NUM_REQ;
      if (vld[idx]) begin
        res = {1'b1, GW'(idx)};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  assign pick_s      = rr_pick(grant_id_r, req_valid);
  assign sel_data_s  = req_data[int'(grant_id_r)*DATA_W +: DATA_W];
  assign sel_valid_s = req_valid[grant_id_r];
  assign sel_last_s  = req_last[grant_id_r] & sel_valid_s;

  // Abort decision while transferring; error outranks last, underrun and length.
  always_comb begin
    abort_s = 1'b0;
    cause_s = abort_cause_r;
    if (error) begin
      abort_s = 1'b1;
      cause_s = CAUSE_ERR;
    end else if (!sel_valid_s) begin
      abort_s = 1'b1;
      cause_s = CAUSE_UNDER;
    end else if (!sel_last_s && (cnt_r == LEN_LAST)) begin
      abort_s = 1'b1;
      cause_s = CAUSE_LEN;
    end else begin
      abort_s = 1'b0;
    end
  end

  // Main arbitration FSM with registered router-side outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= ST_IDLE;
      grant_id_r    <= GW'(NUM_REQ - 1);
      cnt_r         <= 8'd0;
      dut_inp_r     <= {DATA_W{1'b0}};
      inp_valid_r   <= 1'b0;
      abort_pulse_r <= 1'b0;
      abort_cause_r <= 2'd0;
    end else begin
      abort_pulse_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          inp_valid_r <= 1'b0;
          if (!busy && pick_s[GW]) begin
            grant_id_r <= pick_s[GW-1:0];
            cnt_r      <= 8'd0;
            state_r    <= ST_XFER;
          end else begin
            state_r    <= ST_IDLE;
          end
        end
        ST_XFER: begin
          // One-cycle latency from accept to router; dut_inp only moves on a real byte.
          inp_valid_r <= sel_valid_s;
          if (sel_valid_s) begin
            dut_inp_r <= sel_data_s;
            cnt_r     <= cnt_r + 8'd1;
          end else begin
            cnt_r     <= cnt_r;
          end
          if (abort_s) begin
            abort_pulse_r <= 1'b1;
            abort_cause_r <= cause_s;
            state_r       <= sel_last_s ? ST_GAP : ST_DRAIN;
          end else if (sel_last_s) begin
            state_r       <= ST_GAP;
          end else begin
            state_r       <= ST_XFER;
          end
        end
        ST_DRAIN: begin
          // Source bytes are accepted and discarded until its last byte.
          inp_valid_r <= 1'b0;
          if (sel_last_s) begin
            state_r <= ST_GAP;
          end else begin
            state_r <= ST_DRAIN;
          end
        end
        ST_GAP: begin
          inp_valid_r <= 1'b0;
          state_r     <= ST_IDLE;
        end
        default: begin
          inp_valid_r <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  // Ready is a pure decode of the registered state and grant.
  always_comb begin
    req_ready = {NUM_REQ{1'b0}};
    if ((state_r == ST_XFER) || (state_r == ST_DRAIN)) begin
      req_ready[grant_id_r] = 1'b1;
    end else begin
      req_ready = {NUM_REQ{1'b0}};
    end
  end

  assign grant_vld   = (state_r == ST_XFER) || (state_r == ST_DRAIN);
  assign grant_id    = grant_id_r;
  assign dut_inp     = dut_inp_r;
  assign inp_valid   = inp_valid_r;
  assign abort_pulse = abort_pulse_r;
  assign abort_cause = abort_cause_r;

`ifdef ROUTER_ARB_STATS_EN
  logic [31:0] pkt_cnt_r [NUM_REQ];
  logic [31:0] abort_cnt_r;
  logic [31:0] rdata_r;
  logic        pkt_done_s;
  logic        abort_evt_s;

  assign pkt_done_s  = (state_r == ST_XFER) && !abort_s && sel_last_s;
  assign abort_evt_s = (state_r == ST_XFER) && abort_s;

  // Packet/abort counters (free-running, wrap) and registered read port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        pkt_cnt_r[i] <= 32'd0;
      end
      abort_cnt_r <= 32'd0;
      rdata_r     <= 32'd0;
    end else begin
      if (pkt_done_s) begin
        pkt_cnt_r[grant_id_r] <= pkt_cnt_r[grant_id_r] + 32'd1;
      end else begin
        pkt_cnt_r[grant_id_r] <= pkt_cnt_r[grant_id_r];
      end
      if (abort_evt_s) begin
        abort_cnt_r <= abort_cnt_r + 32'd1;
      end else begin
        abort_cnt_r <= abort_cnt_r;
      end
      if (rd) begin
        if (addr < 8'(NUM_REQ)) begin
          rdata_r <= pkt_cnt_r[addr[GW-1:0]];
        end else if (addr == 8'(NUM_REQ)) begin
          rdata_r <= abort_cnt_r;
        end else begin
          rdata_r <= 32'hDEAD_BEEF;
        end
      end else begin
        rdata_r <= rdata_r;
      end
    end
  end

  assign rdata = rdata_r;
`else
  logic stats_unused_s;
  assign stats_unused_s = rd ^ (^addr);
  assign rdata = 32'd0;
`endif

endmodule
